pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sits directly downstream of the system PLL. It consumes the PLL `locked` flag and drives the PLL `rst` input. It then produces a clean, synchronously released active-low system reset for logic clocked by the PLL outputs.
- Runs on the free-running 50 MHz reference clock, the same net that feeds the PLL refclk. It never runs on a PLL output.
- Retries the PLL on lock timeout or lock loss.
- Keeps saturating event counters for debug via the Avalon/PIO status path.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pll_locked synchronizer (min 2).
PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (min 1).
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before retrying the PLL.
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release.
CNT_W, 8, width of the event counters.

Ports:
clk  in  1  free-running 50 MHz reference clock; the block's single clock.
reset_n  in  1  asynchronous, active-low reset.
pll_locked  in  1  PLL locked flag, asynchronous to clk.
clr_cnt  in  1  synchronous pulse; clears both event counters.
pll_rst  out  1  active-high reset to the PLL rst input.
sys_reset_n  out  1  active-low reset for PLL-clocked logic.
ready  out  1  high while in RUN.
state  out  2  current state: 0=PLL_RST, 1=WAIT_LOCK, 2=STABLE, 3=RUN.
lock_loss_cnt  out  CNT_W  saturating count of RUN→PLL_RST transitions.
timeout_cnt  out  CNT_W  saturating count of WAIT_LOCK timeouts.

Behaviour:
- All outputs registered.
- Async reset values: state=PLL_RST, pll_rst=1, sys_reset_n=0, ready=0, both counters=0, internal timer=0, synchronizer flops=0.
- pll_locked passes through a SYNC_STAGES flop chain to give locked_s; its latency is SYNC_STAGES cycles. All decisions use locked_s only.
- Single timer, reset to 0 on every state change.
- PLL_RST:
  - pll_rst=1.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK; pll_rst drops on that edge.
  - locked_s is ignored here.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else, when the timer reaches LOCK_TIMEOUT_CYCLES-1, timeout_cnt++ and go to PLL_RST.
- STABLE:
  - Timer counts consecutive cycles with locked_s=1.
  - If locked_s=0, go to WAIT_LOCK with no counter increment and timer restarted.
  - After LOCK_STABLE_CYCLES consecutive locked cycles, go to RUN.
- RUN:
  - sys_reset_n=1 and ready=1, both asserted on the edge entering RUN.
  - If locked_s=0, lock_loss_cnt++ and go to PLL_RST.
  - sys_reset_n=0, ready=0 and pll_rst=1 all on that same edge.
- sys_reset_n outside RUN:
  - Low in every state other than RUN.
  - Assertion is asynchronous on reset_n; deassertion happens only on a clk edge.
- Counter arithmetic:
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - clr_cnt in the same cycle as an increment gives a result of 1, so the event is not lost.
  - clr_cnt alone gives 0.
- Timer width is clog2 of the largest cycle parameter.
- The timeout comparison is exact; there is no off-by-one slack.
- reset_n asserted mid-operation, in any state, returns all outputs to their reset values immediately.
- pll_locked glitches shorter than one clk period may be missed. Any glitch captured by the synchronizer is treated as a real lock loss.

Test Plan:
Use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=8, CNT_W=2.

1. Nominal lock.
   - Stimulus: release reset_n; raise pll_locked 10 cycles later.
   - Required: pll_rst high for exactly cycles 0–3; state=WAIT_LOCK from cycle 4. STABLE follows 2 cycles after locked rises; sys_reset_n=1 and ready=1 exactly 8 cycles after STABLE entry. Counters stay 0.
2. Timeout retry.
   - Stimulus: hold pll_locked=0.
   - Required: state goes PLL_RST(4)→WAIT_LOCK(64)→PLL_RST repeating; pll_rst re-pulses every 68 cycles. timeout_cnt reads 1, 2, 3, then stays 3 (saturation).
3. Unstable lock.
   - Stimulus: raise pll_locked, drop it after 5 synchronized cycles, raise it again.
   - Required: STABLE→WAIT_LOCK, no counter change, sys_reset_n stays 0. Release occurs 8 full cycles after the second rise is synchronized.
4. Lock loss in RUN.
   - Stimulus: reach RUN, then drop pll_locked for 3 cycles.
   - Required: 2 cycles after the drop, sys_reset_n=0, ready=0, pll_rst=1 and lock_loss_cnt=1. Re-sequencing then proceeds as in scenario 1.
5. Clear collision.
   - Stimulus: pulse clr_cnt on the same cycle a timeout increment occurs with timeout_cnt=2.
   - Required: timeout_cnt=1.
   - Stimulus: pulse clr_cnt alone.
   - Required: both counters 0.
6. Async reset mid-RUN.
   - Stimulus: assert reset_n between clk edges while in RUN.
   - Required: sys_reset_n=0 and pll_rst=1 immediately, without waiting for a clk edge; counters 0; state=PLL_RST.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases a
// synchronously deasserted system reset. Retries on lock timeout or lock loss.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             clr_cnt,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [TMR_W-1:0]       timer_q;
  logic [TMR_W-1:0]       timer_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   timeout_evt;
  logic                   loss_evt;
  logic                   pll_rst_d;
  logic                   run_d;

  // Saturating increment; a clear coinciding with an event keeps that event.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (clr) begin
      res = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

  // Stage: pll_locked synchronizer (locked_s is the only lock view used below)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Stage: state, timer and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLL_RST;
      timer_q     <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pll_rst     <= pll_rst_d;
      sys_reset_n <= run_d;
      ready       <= run_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d     = S_PLL_RST;
          timeout_evt = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d  = S_PLL_RST;
          loss_evt = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
  end

  // Timer restarts on every state change and idles in RUN so it never wraps there.
  always_comb begin
    timer_d = timer_q + 1'b1;
    if ((state_d != state_q) || (state_q == S_RUN)) begin
      timer_d = '0;
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == S_PLL_RST);
    run_d     = (state_d == S_RUN);
  end

  // Stage: debug event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      lock_loss_cnt <= cnt_next(lock_loss_cnt, loss_evt, clr_cnt);
      timeout_cnt   <= cnt_next(timeout_cnt, timeout_evt, clr_cnt);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; cycle c means the interval after the c-th
// rising edge following reset release, and inputs driven in cycle c are seen at edge c+1.
module tb_pll_reset_sequencer;

  localparam int SYNC_STAGES         = 2;
  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_TIMEOUT_CYCLES = 64;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int CNT_W               = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             pll_locked = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             pll_rst;
  logic             sys_reset_n;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [CNT_W-1:0] timeout_cnt;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .clr_cnt(clr_cnt),
    .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n),
    .ready(ready),
    .state(state),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_cnt(timeout_cnt)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0, half a period before the first edge after release.
  task automatic do_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    clr_cnt    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    clr_cnt    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {state, pll_rst, sys_reset_n, ready};
    checks++;
    if (obs !== 5'b00_1_0_0) begin
      errors++;
      $display("FAIL reset_outputs: {state,pll_rst,sys_reset_n,ready} got %b want 00100", obs);
    end
    checks++;
    if ({lock_loss_cnt, timeout_cnt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_counters: got %b want 0000", {lock_loss_cnt, timeout_cnt});
    end
  endtask

  task automatic test_nominal();
    logic [4:0] obs;
    logic [4:0] exp;
    int st;
    do_reset();
    obs = {state, pll_rst, sys_reset_n, ready};
    checks++;
    if (obs !== 5'b00_1_0_0) begin
      errors++;
      $display("FAIL nominal_c0: got %b want 00100", obs);
    end
    for (int c = 1; c <= 22; c++) begin
      tick();
      st  = (c < 4) ? 0 : (c < 13) ? 1 : (c < 21) ? 2 : 3;
      exp = {2'(st), st == 0, st == 3, st == 3};
      obs = {state, pll_rst, sys_reset_n, ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL nominal cyc %0d: {state,pll_rst,sys_reset_n,ready} got %b want %b", c, obs, exp);
      end
      checks++;
      if ({lock_loss_cnt, timeout_cnt} !== 4'b0000) begin
        errors++;
        $display("FAIL nominal_cnt cyc %0d: got %b want 0000", c, {lock_loss_cnt, timeout_cnt});
      end
      if (c == 10) pll_locked = 1'b1;
    end
  endtask

  // Continues from RUN left by test_nominal.
  task automatic test_lock_loss();
    logic [4:0] obs;
    logic [4:0] exp;
    int st;
    pll_locked = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      st  = (c < 3) ? 3 : (c < 7) ? 0 : (c < 8) ? 1 : (c < 16) ? 2 : 3;
      exp = {2'(st), st == 0, st == 3, st == 3};
      obs = {state, pll_rst, sys_reset_n, ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lock_loss cyc %0d: {state,pll_rst,sys_reset_n,ready} got %b want %b", c, obs, exp);
      end
      checks++;
      if (lock_loss_cnt !== ((c < 3) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL lock_loss_cnt cyc %0d: got %0d want %0d", c, lock_loss_cnt, (c < 3) ? 0 : 1);
      end
      if (c == 3) pll_locked = 1'b1;
    end
  endtask

  task automatic test_unstable();
    logic [4:0] obs;
    logic [4:0] exp;
    int st;
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      tick();
      st  = (c < 4) ? 0 : (c < 13) ? 1 : (c < 18) ? 2 : (c < 23) ? 1 : (c < 31) ? 2 : 3;
      exp = {2'(st), st == 0, st == 3, st == 3};
      obs = {state, pll_rst, sys_reset_n, ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL unstable cyc %0d: {state,pll_rst,sys_reset_n,ready} got %b want %b", c, obs, exp);
      end
      checks++;
      if ({lock_loss_cnt, timeout_cnt} !== 4'b0000) begin
        errors++;
        $display("FAIL unstable_cnt cyc %0d: got %b want 0000", c, {lock_loss_cnt, timeout_cnt});
      end
      if (c == 10) pll_locked = 1'b1;
      if (c == 15) pll_locked = 1'b0;
      if (c == 20) pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout();
    logic [4:0] obs;
    logic [4:0] exp;
    int st;
    int tc;
    do_reset();
    for (int c = 1; c <= 280; c++) begin
      tick();
      st  = ((c % 68) < 4) ? 0 : 1;
      tc  = (c / 68 > 3) ? 3 : c / 68;
      exp = {2'(st), st == 0, 1'b0, 1'b0};
      obs = {state, pll_rst, sys_reset_n, ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout cyc %0d: {state,pll_rst,sys_reset_n,ready} got %b want %b", c, obs, exp);
      end
      checks++;
      if ({lock_loss_cnt, timeout_cnt} !== {2'd0, 2'(tc)}) begin
        errors++;
        $display("FAIL timeout_cnt cyc %0d: got loss=%0d timeout=%0d want loss=0 timeout=%0d",
                 c, lock_loss_cnt, timeout_cnt, tc);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    pll_locked = 1'b1;
    for (int c = 1; c <= 292; c++) begin
      tick();
      if (c == 13) begin
        checks++;
        if (state !== 2'd3) begin
          errors++;
          $display("FAIL clear_run: state got %0d want 3", state);
        end
      end
      if (c == 14) pll_locked = 1'b0;
      if (c == 17) begin
        checks++;
        if ({state, lock_loss_cnt} !== {2'd0, 2'd1}) begin
          errors++;
          $display("FAIL clear_loss: state/loss got %0d/%0d want 0/1", state, lock_loss_cnt);
        end
      end
      if (c == 85 || c == 153 || c == 220 || c == 289) begin
        checks++;
        if (timeout_cnt !== ((c == 85) ? 2'd1 : 2'd2)) begin
          errors++;
          $display("FAIL clear_pre cyc %0d: timeout_cnt got %0d want %0d", c, timeout_cnt, (c == 85) ? 1 : 2);
        end
      end
      if (c == 220) clr_cnt = 1'b1;
      if (c == 221 || c == 222) begin
        clr_cnt = 1'b0;
        checks++;
        if ({lock_loss_cnt, timeout_cnt} !== {2'd0, 2'd1}) begin
          errors++;
          $display("FAIL clear_collision cyc %0d: loss/timeout got %0d/%0d want 0/1", c, lock_loss_cnt, timeout_cnt);
        end
      end
      if (c == 290) clr_cnt = 1'b1;
      if (c == 291) begin
        clr_cnt = 1'b0;
        checks++;
        if ({lock_loss_cnt, timeout_cnt} !== 4'b0000) begin
          errors++;
          $display("FAIL clear_alone: loss/timeout got %0d/%0d want 0/0", lock_loss_cnt, timeout_cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] obs;
    do_reset();
    pll_locked = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (c == 14) pll_locked = 1'b0;
      if (c == 15) pll_locked = 1'b1;
      if (c == 13 || c == 30 || c == 31) begin
        checks++;
        if ({state, sys_reset_n} !== 3'b11_1) begin
          errors++;
          $display("FAIL async_pre_run cyc %0d: state/sys_reset_n got %0d/%b want 3/1", c, state, sys_reset_n);
        end
      end
      if (c == 17) begin
        checks++;
        if ({state, lock_loss_cnt} !== {2'd0, 2'd1}) begin
          errors++;
          $display("FAIL async_glitch_loss: state/loss got %0d/%0d want 0/1", state, lock_loss_cnt);
        end
      end
    end
    #5;
    reset_n = 1'b0;
    #1;
    obs = {state, pll_rst, sys_reset_n, ready};
    checks++;
    if (obs !== 5'b00_1_0_0) begin
      errors++;
      $display("FAIL async_reset: {state,pll_rst,sys_reset_n,ready} got %b want 00100", obs);
    end
    checks++;
    if ({lock_loss_cnt, timeout_cnt} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_cnt: got %b want 0000", {lock_loss_cnt, timeout_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_unstable();
    test_timeout();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
